outrow_check: RTL

// - Synthesizable, self-checking output row: sinks values from NCH bottom-edge core ports

---
 rtl/tis_pkg.sv | 12 +
 rtl/outrow_check_if.sv | 12 +
 rtl/outrow_chan.sv | 69 ++++++
 rtl/outrow_check.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared types for the core-handshake row blocks (inrow, sink, outrow_check).
package tis_pkg;
    localparam int W_DEF = 11;

    typedef logic signed [W_DEF-1:0] tis_val_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } hs_state_e;
endpackage

// File: rtl/outrow_check_if.sv
// Bottom-edge core handshake bundle: producer (master) drives rready/data, sink (slave) pulses read.
interface outrow_check_if #(
    parameter int NCH = 4,
    parameter int W   = tis_pkg::W_DEF
);
    logic [NCH-1:0]        rready;
    logic [NCH-1:0]        read;
    logic [NCH-1:0][W-1:0] data;

    modport master (output rready, output data, input read);
    modport slave  (input rready, input data, output read);
endinterface

// File: rtl/outrow_chan.sv
// One output channel: IDLE/ACK/HOLD handshake, expected-stream index and per-value compare.
module outrow_chan
    import tis_pkg::*;
#(
    parameter  int W     = W_DEF,
    parameter  int DEPTH = 64,
    localparam int IW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  rready_i,
    input  logic [W-1:0]          data_i,
    input  logic [5:0]            length_i,
    input  logic [DEPTH-1:0][W-1:0] exp_i,
    output logic                  read_o,
    output logic                  busy_o,
    output logic                  complete_o,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic [W-1:0]          miss_exp_o
);
    hs_state_e     state_q;
    logic          read_q;
    logic [IW-1:0] idx_q;
    logic          in_range;
    logic [W-1:0]  exp_sel;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (rready_i && en_i) begin
                    state_q <= ACK;
                    read_q  <= 1'b1;
                end
                ACK: begin
                    state_q <= HOLD;
                    read_q  <= 1'b0;
                    if (idx_q != IW'(DEPTH)) idx_q <= idx_q + IW'(1);
                end
                HOLD:    state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        in_range = (int'(idx_q) < int'(length_i)) && (int'(idx_q) < DEPTH);
        exp_sel  = '0;
        if (in_range) exp_sel = exp_i[idx_q[AW-1:0]];
        hit_o      = (state_q == ACK) && in_range && (data_i == exp_sel);
        miss_o     = (state_q == ACK) && !hit_o;
        miss_exp_o = exp_sel;
    end

    assign read_o     = read_q;
    assign busy_o     = (state_q != IDLE);
    assign complete_o = (int'(idx_q) == int'(length_i));
endmodule

// File: rtl/outrow_check.sv
// Self-checking output row: NCH channel sinks plus counters, first-error capture, timeout, done/pass.
module outrow_check
    import tis_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int W       = W_DEF,
    parameter  int DEPTH   = 64,
    parameter  int TIMEOUT = 4096,
    localparam int CW      = $clog2(NCH * DEPTH + 1),
    localparam int FW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TW      = $clog2(TIMEOUT + 1),
    localparam int HW      = $clog2(NCH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NCH-1:0][5:0]         length_i,
    input  logic [NCH*DEPTH-1:0][W-1:0] exp_data_i,
    outrow_check_if.slave               bus,
    output logic [CW-1:0]               correct_o,
    output logic [CW-1:0]               errors_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [NCH-1:0]              ch_fail_o,
    output logic [FW-1:0]               first_ch_o,
    output logic [W-1:0]                first_got_o,
    output logic [W-1:0]                first_exp_o
);
    logic [NCH-1:0]        read_w, busy_w, complete_w, hit_w, miss_w;
    logic [NCH-1:0][W-1:0] miss_exp_w;

    logic [CW-1:0]  correct_q, correct_d, errors_q, errors_d;
    logic [CW:0]    correct_sum, errors_sum;
    logic [HW-1:0]  hit_cnt, miss_cnt;
    logic [TW-1:0]  idle_q, idle_d;
    logic           done_q, done_d, pass_q, pass_d, timed_out_q, timed_out_d;
    logic           timeout_hit, all_done, found;
    logic [NCH-1:0] ch_fail_q, ch_fail_d;
    logic [FW-1:0]  first_ch_q, first_ch_d;
    logic [W-1:0]   first_got_q, first_got_d, first_exp_q, first_exp_d;

    // A timed-out check stops accepting; a completed one keeps draining so late values count as errors.
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        outrow_chan #(.W(W), .DEPTH(DEPTH)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en_i       (!timed_out_q),
            .rready_i   (bus.rready[c]),
            .data_i     (bus.data[c]),
            .length_i   (length_i[c]),
            .exp_i      (exp_data_i[c*DEPTH +: DEPTH]),
            .read_o     (read_w[c]),
            .busy_o     (busy_w[c]),
            .complete_o (complete_w[c]),
            .hit_o      (hit_w[c]),
            .miss_o     (miss_w[c]),
            .miss_exp_o (miss_exp_w[c])
        );
    end

    assign bus.read = read_w;

    always_comb begin
        hit_cnt  = '0;
        miss_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            hit_cnt  = hit_cnt + HW'(hit_w[c]);
            miss_cnt = miss_cnt + HW'(miss_w[c]);
        end
        correct_sum = (CW+1)'(correct_q) + (CW+1)'(hit_cnt);
        errors_sum  = (CW+1)'(errors_q) + (CW+1)'(miss_cnt);
        correct_d   = correct_sum[CW] ? '1 : correct_sum[CW-1:0];
        errors_d    = errors_sum[CW] ? '1 : errors_sum[CW-1:0];

        // Ascending scan: the lowest channel wins among simultaneous first errors.
        found       = 1'b0;
        first_ch_d  = first_ch_q;
        first_got_d = first_got_q;
        first_exp_d = first_exp_q;
        for (int c = 0; c < NCH; c++) begin
            if (!found && miss_w[c] && (errors_q == '0)) begin
                found       = 1'b1;
                first_ch_d  = FW'(c);
                first_got_d = bus.data[c];
                first_exp_d = miss_exp_w[c];
            end
        end

        idle_d      = (|read_w) ? '0 : ((idle_q == '1) ? idle_q : idle_q + TW'(1));
        timeout_hit = !done_q && (int'(idle_d) == TIMEOUT - 1);
        all_done    = (&complete_w) && !(|busy_w);
        done_d      = done_q || all_done || timeout_hit;
        timed_out_d = timed_out_q || timeout_hit;
        ch_fail_d   = ch_fail_q | miss_w | (timeout_hit ? ~complete_w : '0);
        pass_d      = done_d && (errors_d == '0) && (&complete_w) && !timed_out_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            correct_q   <= '0;
            errors_q    <= '0;
            idle_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            ch_fail_q   <= '0;
            first_ch_q  <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
        end else begin
            correct_q   <= correct_d;
            errors_q    <= errors_d;
            idle_q      <= idle_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            ch_fail_q   <= ch_fail_d;
            first_ch_q  <= first_ch_d;
            first_got_q <= first_got_d;
            first_exp_q <= first_exp_d;
        end
    end

    assign correct_o   = correct_q;
    assign errors_o    = errors_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign ch_fail_o   = ch_fail_q;
    assign first_ch_o  = first_ch_q;
    assign first_got_o = first_got_q;
    assign first_exp_o = first_exp_q;
endmodule
